key_event_unit: RTL and testbench
=================================

# key_event_unit

Input-conditioning stage that sits directly upstream of the game top level. It takes the raw, active-low push-button lines and produces clean per-key level, press, release and auto-repeat pulses, replacing per-button debouncer instances. All keys are processed in parallel from one shared millisecond-tick prescaler. The game FSM consumes the single-cycle pulses (Roll, Select, Prev, Next); auto-repeat lets a held Prev/Next key step through categories.

## Interface
- `N_KEYS`, default 6: number of key inputs.
- `TICK_DIV`, default 50000: clock cycles per debounce tick (1 ms at 50 MHz); must be ≥2.
- `DEBOUNCE_TICKS`, default 20: consecutive stable ticks required to accept a level change; 1–255.
- `REPEAT_DELAY_TICKS`, default 500: ticks from accepted press to first repeat; 1–4095.
- `REPEAT_RATE_TICKS`, default 100: ticks between subsequent repeats; 1–4095.
- `REPEAT_MASK`, default 6'b110000: per-key auto-repeat enable (bit i = key i).
- `clk`, input, 1: system clock. One clock; all logic rises on `clk`.
- `reset`, input, 1: reset, synchronous, active-high.
- `key_n`, input, N_KEYS: raw asynchronous buttons, 0 = pressed.
- `key_level`, output, N_KEYS: debounced state, 1 = pressed.
- `key_press`, output, N_KEYS: 1-cycle pulse on accepted press.
- `key_release`, output, N_KEYS: 1-cycle pulse on accepted release.
- `key_repeat`, output, N_KEYS: 1-cycle auto-repeat pulse.
- `tick`, output, 1: prescaler tick, 1 cycle every `TICK_DIV` cycles (debug and test use).

## Operation
- Synchronizer: two flops per key on `key_n`, reset to 1 (released). Inverted sync output = `sampled[i]`.
- Prescaler: counter 0..TICK_DIV-1. `tick`=1 in the cycle where count == TICK_DIV-1, then wraps to 0.
- Debounce, per key, evaluated only on `tick` cycles:
  - `sampled[i]` == `key_level[i]`: stable counter cleared to 0.
  - Otherwise the counter increments. When it would reach `DEBOUNCE_TICKS`, `key_level[i]` toggles, the counter clears, and `key_press[i]` (rising) or `key_release[i]` (falling) is asserted in the same cycle as the level change.
  - Any tick with a matching sample (bounce) restarts the count.
- Auto-repeat, per key with `REPEAT_MASK[i]`=1. States: IDLE, DELAY, REPEAT.
  - Accepted press → DELAY, hold counter = 0.
  - On each tick in DELAY the counter increments. At `REPEAT_DELAY_TICKS`: pulse `key_repeat[i]`, enter REPEAT, counter = 0.
  - On each tick in REPEAT the counter increments. At `REPEAT_RATE_TICKS`: pulse, counter = 0.
  - Accepted release, or `key_level[i]`=0 → IDLE. No repeat is issued in or after the release cycle.
  - Masked-off keys stay in IDLE; `key_repeat[i]`=0.
  - `key_press` and `key_repeat` never assert in the same cycle for the same key.
- Keys are fully independent. Simultaneous presses on several keys yield simultaneous pulses.

## Timing
- Reset values: `key_level`, `key_press`, `key_release`, `key_repeat`, `tick` = 0. Prescaler, debounce and hold counters = 0. Repeat FSMs = IDLE. Sync flops = 1.
- Reset asserted mid-operation: all of the above are restored on the next edge, and no pulses occur. A key still held after reset is treated as a new press and is accepted after the full debounce period.
- Input to `key_press` latency: 2 sync cycles, plus alignment to the next tick, plus `DEBOUNCE_TICKS` ticks. The bound is 2 + (DEBOUNCE_TICKS−1)·TICK_DIV + 1 … 2 + DEBOUNCE_TICKS·TICK_DIV cycles.
- All outputs are registered. Pulses are exactly 1 cycle wide and occur only in `tick` cycles.

## Configuration
- `KEY_AUTOREPEAT_EN` defined: the repeat FSMs and hold counters are built as described above.
- `KEY_AUTOREPEAT_EN` undefined: no repeat logic is synthesized. `key_repeat` is tied to 0; level, press, release and tick behaviour are unchanged.

## Test plan
Bench parameters: TICK_DIV=4, DEBOUNCE_TICKS=3, REPEAT_DELAY_TICKS=5, REPEAT_RATE_TICKS=2, macro defined.

- Reset: assert `reset` with all `key_n` = 0 → all outputs 0. Release `reset` → `key_press`=all-ones exactly once, 10–14 cycles later; `key_repeat` only on masked keys.
- Clean press of key 0 held 40 cycles, then released → one `key_press[0]`, `key_level[0]`=1, one `key_release[0]`, zero `key_repeat[0]` (bit masked off).
- Bounce on key 0: toggle `key_n[0]` every 5 cycles for 60 cycles → no press or release pulses; `key_level[0]` stays 0.
- Repeat on key 4: hold 12 ticks past the accepted press → `key_repeat[4]` on ticks 5, 7, 9, 11 after the press (4 pulses). Release → no further repeats.
- Keys 4 and 5 pressed in the same cycle → `key_press[4]` and `key_press[5]` in the same cycle, and their repeats coincide.
- Mid-repeat reset: assert `reset` during REPEAT on key 5 → all outputs 0 the next cycle. With the key still held → new `key_press[5]` after debounce; first repeat 5 ticks later.
- Macro undefined, repeat scenario re-run → `key_repeat` stays 0; press and release pulses are identical to the defined build.

Source files
------------

// File: rtl/key_event_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : key_event_unit_if
// Description : Key bundle between the raw button pins and the game logic.
//               master = button/stimulus side, slave = key_event_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface key_event_unit_if #(
    parameter int N_KEYS = 6
);
    logic [N_KEYS-1:0] key_n;        // raw buttons, 0 = pressed
    logic [N_KEYS-1:0] key_level;    // debounced level, 1 = pressed
    logic [N_KEYS-1:0] key_press;    // 1-cycle pulse on accepted press
    logic [N_KEYS-1:0] key_release;  // 1-cycle pulse on accepted release
    logic [N_KEYS-1:0] key_repeat;   // 1-cycle auto-repeat pulse
    logic              tick;         // prescaler tick

    modport master (
        output key_n,
        input  key_level, key_press, key_release, key_repeat, tick
    );

    modport slave (
        input  key_n,
        output key_level, key_press, key_release, key_repeat, tick
    );
endinterface
`default_nettype wire

// File: rtl/key_event_unit.sv
`default_nettype none
// ============================================================================
// Module      : key_event_unit
// Description : Per-key synchronizer, tick-based debouncer and press/release
//               pulse generator with optional auto-repeat, all keys sharing
//               one prescaler. Auto-repeat is built only when the macro
//               KEY_AUTOREPEAT_EN is defined; otherwise key_repeat is 0.
// Revision    : 1.0 - initial release
// ============================================================================
module key_event_unit #(
    parameter int                N_KEYS             = 6,
    parameter int                TICK_DIV           = 50000,
    parameter int                DEBOUNCE_TICKS     = 20,
    parameter int                REPEAT_DELAY_TICKS = 500,
    parameter int                REPEAT_RATE_TICKS  = 100,
    parameter logic [N_KEYS-1:0] REPEAT_MASK        = N_KEYS'(6'b110000)
) (
    input  wire logic         clk,
    input  wire logic         reset,
    key_event_unit_if.slave   kif
);

    localparam int              CNT_W         = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] c_tick_last  = CNT_W'(TICK_DIV - 1);
    // Per-key state is updated one cycle ahead of the tick cycle so that the
    // registered level/pulse outputs line up with the registered tick output.
    localparam logic [CNT_W-1:0] c_eval_cnt   = CNT_W'(TICK_DIV - 2);
    localparam logic [7:0]      c_deb_last    = 8'(DEBOUNCE_TICKS - 1);

    // Elaboration-time range check of the configuration
    if (TICK_DIV < 2 || DEBOUNCE_TICKS < 1 || DEBOUNCE_TICKS > 255 ||
        REPEAT_DELAY_TICKS < 1 || REPEAT_DELAY_TICKS > 4095 ||
        REPEAT_RATE_TICKS < 1 || REPEAT_RATE_TICKS > 4095 ||
        $bits(REPEAT_MASK) != N_KEYS) begin : g_bad_cfg
        $error("key_event_unit: parameter out of range");
    end

    logic [N_KEYS-1:0] sync1_q, sync2_q;
    logic [N_KEYS-1:0] sampled;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q;
    logic              eval_tick;

    // Two-flop synchronizer, idles at "released"
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '1;
            sync2_q <= '1;
        end else begin
            sync1_q <= kif.key_n;
            sync2_q <= sync1_q;
        end
    end

    assign sampled   = ~sync2_q;
    assign eval_tick = (cnt_q == c_eval_cnt);
    assign cnt_d     = (cnt_q == c_tick_last) ? '0 : cnt_q + CNT_W'(1);

    // Shared prescaler; tick is high while the count sits at TICK_DIV-1
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= eval_tick;
        end
    end

    assign kif.tick = tick_q;

`ifdef KEY_AUTOREPEAT_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_REPEAT = 2'd2
    } rep_state_e;

    localparam logic [11:0] c_delay_last = 12'(REPEAT_DELAY_TICKS - 1);
    localparam logic [11:0] c_rate_last  = 12'(REPEAT_RATE_TICKS - 1);
`endif

    for (genvar i = 0; i < N_KEYS; i++) begin : g_key
        logic [7:0] stab_q, stab_d;
        logic       lvl_q, lvl_d;
        logic       press_q, press_d;
        logic       rel_q, rel_d;

        // Count consecutive disagreeing ticks; the last one flips the level
        always_comb begin
            stab_d  = stab_q;
            lvl_d   = lvl_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
            if (eval_tick) begin
                if (sampled[i] == lvl_q) begin
                    stab_d = '0;
                end else if (stab_q == c_deb_last) begin
                    stab_d  = '0;
                    lvl_d   = ~lvl_q;
                    press_d = ~lvl_q;
                    rel_d   = lvl_q;
                end else begin
                    stab_d = stab_q + 8'd1;
                end
            end
        end

        // Debounce counter, level and edge-pulse registers
        always_ff @(posedge clk) begin
            if (reset) begin
                stab_q  <= '0;
                lvl_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                stab_q  <= stab_d;
                lvl_q   <= lvl_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        assign kif.key_level[i]   = lvl_q;
        assign kif.key_press[i]   = press_q;
        assign kif.key_release[i] = rel_q;

`ifdef KEY_AUTOREPEAT_EN
        if (REPEAT_MASK[i]) begin : g_rep
            rep_state_e  state_q, state_d;
            logic [11:0] hold_q, hold_d;
            logic        rep_q, rep_d;

            // Repeat FSM: a press arms the delay, release/low level disarms
            // with priority so no repeat can fire in the release cycle
            always_comb begin
                state_d = state_q;
                hold_d  = hold_q;
                rep_d   = 1'b0;
                if (press_d) begin
                    state_d = S_DELAY;
                    hold_d  = '0;
                end else if (rel_d || !lvl_q) begin
                    state_d = S_IDLE;
                    hold_d  = '0;
                end else if (eval_tick) begin
                    case (state_q)
                        S_DELAY: begin
                            if (hold_q == c_delay_last) begin
                                rep_d   = 1'b1;
                                state_d = S_REPEAT;
                                hold_d  = '0;
                            end else begin
                                hold_d = hold_q + 12'd1;
                            end
                        end
                        S_REPEAT: begin
                            if (hold_q == c_rate_last) begin
                                rep_d  = 1'b1;
                                hold_d = '0;
                            end else begin
                                hold_d = hold_q + 12'd1;
                            end
                        end
                        default: begin
                            state_d = S_IDLE;
                            hold_d  = '0;
                        end
                    endcase
                end
            end

            // Repeat FSM state, hold counter and repeat pulse register
            always_ff @(posedge clk) begin
                if (reset) begin
                    state_q <= S_IDLE;
                    hold_q  <= '0;
                    rep_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    hold_q  <= hold_d;
                    rep_q   <= rep_d;
                end
            end

            assign kif.key_repeat[i] = rep_q;
        end else begin : g_norep
            assign kif.key_repeat[i] = 1'b0;
        end
`else
        assign kif.key_repeat[i] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_key_event_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_key_event_unit
// Description : Self-checking bench for key_event_unit. Expected pulses are
//               queued by the stimulus and popped by a monitor that compares
//               kind, key mask and tick distance from the key's press.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_key_event_unit;

    localparam int N = 6;
    localparam int K_PRESS = 0;
    localparam int K_REL   = 1;
    localparam int K_REP   = 2;

    typedef struct {
        int          kind;
        logic [N-1:0] mask;
        int          dt;     // ticks since the key's press, -1 = don't care
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    int   tests = 0;
    int   fails = 0;
    exp_t exp_q[$];
    int   tick_cnt = 0;
    int   cyc_n = 0;
    int   last_tick_cyc = -1;
    int   press_tick[N];

    key_event_unit_if #(.N_KEYS(N)) kif ();

    key_event_unit #(
        .N_KEYS             (N),
        .TICK_DIV           (4),
        .DEBOUNCE_TICKS     (3),
        .REPEAT_DELAY_TICKS (5),
        .REPEAT_RATE_TICKS  (2),
        .REPEAT_MASK        (6'b110000)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .kif   (kif.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int kind, input logic [N-1:0] mask, input int dt);
        exp_t e;
        e.kind = kind;
        e.mask = mask;
        e.dt   = dt;
        exp_q.push_back(e);
    endtask

    task automatic sb_check(input int kind, input logic [N-1:0] mask, input int dt);
        exp_t e;
        tests++;
        assert (exp_q.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_pulse: kind %0d mask %b with empty queue", kind, mask);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("sb_kind", kind, e.kind);
            chk("sb_mask", 32'(mask), 32'(e.mask));
            if (e.dt >= 0) chk("sb_dtick", dt, e.dt);
        end
    endtask

    // Monitor: tick period, pulses only on ticks, scoreboard pops
    always @(negedge clk) begin
        int lo;
        cyc_n++;
        if (reset) begin
            last_tick_cyc = -1;
        end else begin
            if (kif.tick === 1'b1) begin
                tick_cnt++;
                if (last_tick_cyc >= 0) chk("tick_period", cyc_n - last_tick_cyc, 4);
                last_tick_cyc = cyc_n;
            end
            if ((kif.key_press | kif.key_release | kif.key_repeat) != '0) begin
                chk("pulse_on_tick", 32'(kif.tick), 1);
                if (kif.key_press != '0) begin
                    for (int k = 0; k < N; k++) if (kif.key_press[k]) press_tick[k] = tick_cnt;
                    sb_check(K_PRESS, kif.key_press, -1);
                end
                if (kif.key_release != '0) sb_check(K_REL, kif.key_release, -1);
                if (kif.key_repeat != '0) begin
                    lo = 0;
                    for (int k = N - 1; k >= 0; k--) if (kif.key_repeat[k]) lo = k;
                    sb_check(K_REP, kif.key_repeat, tick_cnt - press_tick[lo]);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        chk({tag, "_level"},   32'(kif.key_level),   0);
        chk({tag, "_press"},   32'(kif.key_press),   0);
        chk({tag, "_release"}, 32'(kif.key_release), 0);
        chk({tag, "_repeat"},  32'(kif.key_repeat),  0);
        chk({tag, "_tick"},    32'(kif.tick),        0);
    endtask

    task automatic wait_press(input logic [N-1:0] mask, input int budget);
        int found = 0;
        for (int c = 0; c < budget && found == 0; c++) begin
            @(negedge clk);
            if ((kif.key_press & mask) != '0) found = 1;
        end
        chk("press_seen", found, 1);
    endtask

    task automatic wait_ticks(input int n);
        int seen = 0;
        for (int c = 0; c < n * 4 + 8 && seen < n; c++) begin
            @(negedge clk);
            if (kif.tick === 1'b1) seen++;
        end
        chk("ticks_seen", seen, n);
    endtask

    // Cycles from reset release to the first press on the given keys
    task automatic reset_latency(input logic [N-1:0] mask, input string tag);
        int lat = 0;
        for (int c = 1; c <= 30 && lat == 0; c++) begin
            @(negedge clk);
            if ((kif.key_press & mask) != '0) lat = c;
        end
        chk(tag, 32'((lat >= 10) && (lat <= 14)), 1);
    endtask

    task automatic drain(input int budget);
        for (int c = 0; c < budget && exp_q.size() != 0; c++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
        repeat (20) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N; k++) press_tick[k] = 0;
        // Reset with every key held down
        reset     = 1'b1;
        kif.key_n = '0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        push(K_PRESS, 6'b111111, -1);
        push(K_REL,   6'b111111, -1);
        reset = 1'b0;
        reset_latency(6'b111111, "reset_press_latency");
        kif.key_n = '1;
        drain(80);

        // Clean press of key 0
        kif.key_n[0] = 1'b0;
        push(K_PRESS, 6'b000001, -1);
        push(K_REL,   6'b000001, -1);
        repeat (30) @(negedge clk);
        chk("key0_level_held", 32'(kif.key_level), 32'h01);
        repeat (10) @(negedge clk);
        kif.key_n[0] = 1'b1;
        drain(60);
        chk("key0_level_released", 32'(kif.key_level), 0);

        // Bounce on key 0: never stable long enough
        for (int t = 0; t < 12; t++) begin
            kif.key_n[0] = ~kif.key_n[0];
            repeat (5) @(negedge clk);
            chk("bounce_level", 32'(kif.key_level[0]), 0);
        end
        repeat (30) @(negedge clk);
        chk("bounce_no_events", exp_q.size(), 0);

        // Auto-repeat on key 4
        kif.key_n[4] = 1'b0;
        push(K_PRESS, 6'b010000, -1);
`ifdef KEY_AUTOREPEAT_EN
        push(K_REP, 6'b010000, 5);
        push(K_REP, 6'b010000, 7);
        push(K_REP, 6'b010000, 9);
        push(K_REP, 6'b010000, 11);
`endif
        push(K_REL, 6'b010000, -1);
        wait_press(6'b010000, 40);
        wait_ticks(10);
        kif.key_n[4] = 1'b1;
        drain(80);

        // Keys 4 and 5 together
        kif.key_n[5:4] = 2'b00;
        push(K_PRESS, 6'b110000, -1);
`ifdef KEY_AUTOREPEAT_EN
        push(K_REP, 6'b110000, 5);
        push(K_REP, 6'b110000, 7);
`endif
        push(K_REL, 6'b110000, -1);
        wait_press(6'b110000, 40);
        wait_ticks(6);
        kif.key_n[5:4] = 2'b11;
        drain(80);

        // Reset while key 5 is repeating, key kept held through reset
        kif.key_n[5] = 1'b0;
        push(K_PRESS, 6'b100000, -1);
`ifdef KEY_AUTOREPEAT_EN
        push(K_REP, 6'b100000, 5);
        push(K_REP, 6'b100000, 7);
`endif
        wait_press(6'b100000, 40);
        wait_ticks(8);
        chk("pre_reset_queue", exp_q.size(), 0);
        reset = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        @(negedge clk);
        push(K_PRESS, 6'b100000, -1);
`ifdef KEY_AUTOREPEAT_EN
        push(K_REP, 6'b100000, 5);
        push(K_REP, 6'b100000, 7);
`endif
        push(K_REL, 6'b100000, -1);
        reset = 1'b0;
        reset_latency(6'b100000, "rearm_press_latency");
        wait_ticks(6);
        kif.key_n[5] = 1'b1;
        drain(80);
        chk("final_level", 32'(kif.key_level), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
